rol_rotate_sequencer: RTL and testbench
=======================================

# rol_rotate_sequencer

Upstream command stage for the 4-bit rotate-left barrel shifter. Accepts a rotate command (seed word, rotate amount, repeat count) over a valid/ready handshake. Drives the shifter's data and amount inputs, then feeds each shifter result back as the next operand. Streams every intermediate result downstream over a second valid/ready handshake, with the final beat flagged.

## Interface
- WIDTH, 4, data word width; must equal the shifter width.
- AMT_W, 2, rotate-amount width, $clog2(WIDTH).
- CNT_W, 4, repeat-count width.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset; one clock; reset is asynchronous and active-low.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  sequencer idle, command accepted when both high.
- cmd_data_i  input  WIDTH  seed word.
- cmd_amt_i  input  AMT_W  rotate-left amount per step.
- cmd_steps_i  input  CNT_W  beat count minus one (N means N+1 beats).
- sh_a_o  output  WIDTH  operand to shifter a_i.
- sh_amt_o  output  AMT_W  amount to shifter amt_i.
- sh_y_i  input  WIDTH  shifter result y_o (combinational).
- out_valid_o  output  1  result beat valid.
- out_ready_i  input  1  downstream accepts beat.
- out_data_o  output  WIDTH  rotated word.
- out_last_o  output  1  final beat of command; qualified by out_valid_o.
- busy_o  output  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ROTATE, HOLD; held in registers, reset to IDLE.
- IDLE: cmd_ready_o=1.
  - On cmd_valid_i, latch cmd_data_i into operand register, cmd_amt_i into amount register, cmd_steps_i into remaining counter.
  - Go to ROTATE.
- ROTATE (exactly one cycle): sh_a_o/sh_amt_o show operand/amount registers. At the clock edge:
  - capture sh_y_i into out_data_o;
  - set out_valid_o;
  - set out_last_o = (remaining == 0);
  - go to HOLD.
- HOLD: out_valid_o=1, out_data_o and out_last_o stable until out_ready_i.
  - On handshake with last=1: clear out_valid_o, go to IDLE.
  - On handshake with last=0: operand <= out_data_o, remaining <= remaining-1, clear out_valid_o, go to ROTATE.
- cmd_valid_i outside IDLE is ignored; cmd_ready_o=0 in ROTATE and HOLD.
- Amount is fixed for the whole command. Rotation is modulo WIDTH by construction.
- Remaining counter is CNT_W wide. Max command is 2^CNT_W beats (16 by default). Counter never decrements below 0.
- Combinational outputs:
  - sh_a_o and sh_amt_o are register outputs at all times, including in IDLE.
  - cmd_ready_o and busy_o decode directly from state.

## Timing
- Reset values:
  - cmd_ready_o=1, busy_o=0.
  - out_valid_o=0, out_last_o=0, out_data_o=0.
  - sh_a_o=0, sh_amt_o=0.
  - internal remaining counter=0.
- Command accepted at edge T: ROTATE during cycle T+1; first beat valid from T+2.
- Each further beat: valid 2 cycles after the previous handshake edge. Peak throughput is one beat per 2 cycles.
- After the last handshake: cmd_ready_o=1 in the next cycle. No back-to-back overlap of commands.
- Backpressure: out_valid_o held with data/last stable for any number of cycles.
- Reset mid-command: async clear to reset values. The partial command is discarded and no further beats are issued.

## Structure
- Shared package rol_pkg:
  - state enum rol_seq_state_e {IDLE, ROTATE, HOLD};
  - default WIDTH, AMT_W, CNT_W localparams.
  - The package is also used by the shifter bench.
- No internal sub-module. rol_barrel_shifter is instantiated beside this block at the parent level, with sh_a_o->a_i, sh_amt_o->amt_i, y_o->sh_y_i.
- Bench instantiates both the sequencer and the shifter.

## Test plan
- Seed 1011, amt 01, steps 3, out_ready_i=1 -> beats 0111, 1110, 1101, 1011; out_last_o only on the 4th; cmd_ready_o high the cycle after.
- Seed 1011, amt 10, steps 0 -> single beat 1110 with out_last_o=1; first valid exactly 2 cycles after acceptance.
- Seed 0110, amt 00, steps 2 -> three beats of 0110, last on the third.
- Seed 1000, amt 11, steps 1, out_ready_i low 5 cycles on beat 1 -> 0100 held stable 5 cycles, then 0010 with last.
- Second command asserted while busy -> not accepted; no output change until IDLE, then accepted.
- rst_ni pulsed low during HOLD of beat 2 -> all outputs at reset values immediately; no further beats; next command runs normally.

Source files
------------

// File: rtl/rol_pkg.sv
// rol_pkg
// Shared definitions for the rotate-left datapath: default widths and the
// command sequencer state encoding. Imported by the sequencer, the barrel
// shifter and their benches.
package rol_pkg;

    localparam int unsigned ROL_WIDTH = 4;
    localparam int unsigned ROL_AMT_W = $clog2(ROL_WIDTH);
    localparam int unsigned ROL_CNT_W = 4;

    // state  | meaning
    // IDLE   | waiting for a command, cmd_ready_o high
    // ROTATE | shifter sees operand/amount, result captured at the edge
    // HOLD   | result beat presented downstream until accepted
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        HOLD   = 2'd2
    } rol_seq_state_e;

endpackage

// File: rtl/rol_barrel_shifter.sv
// rol_barrel_shifter
// Combinational rotate-left of a WIDTH-bit word by amt_i positions.
// Ports:
//   a_i    operand word
//   amt_i  rotate-left amount (modulo WIDTH by construction)
//   y_o    rotated word
module rol_barrel_shifter
    import rol_pkg::*;
#(
    parameter int unsigned WIDTH = ROL_WIDTH,
    parameter int unsigned AMT_W = ROL_AMT_W
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [AMT_W-1:0] amt_i,
    output logic [WIDTH-1:0] y_o
);

    // For amt_i == 0 the right shift is by WIDTH and yields zero, so the OR
    // degenerates to a pass-through.
    assign y_o = (a_i << amt_i) | (a_i >> (WIDTH - 32'(amt_i)));

endmodule

// File: rtl/rol_rotate_sequencer.sv
// rol_rotate_sequencer
// Command stage in front of the rotate-left barrel shifter. Accepts a
// (seed, amount, repeat) command, drives the shifter, feeds each result back
// as the next operand and streams every intermediate result downstream,
// flagging the final beat.
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_data_i                 seed word
//   cmd_amt_i                  rotate-left amount per step
//   cmd_steps_i                beat count minus one
//   sh_a_o / sh_amt_o          operand and amount to the shifter
//   sh_y_i                     shifter result
//   out_valid_o / out_ready_i  result handshake
//   out_data_o / out_last_o    result word, final-beat flag
//   busy_o                     high whenever not IDLE
module rol_rotate_sequencer
    import rol_pkg::*;
#(
    parameter int unsigned WIDTH = ROL_WIDTH,
    parameter int unsigned AMT_W = ROL_AMT_W,
    parameter int unsigned CNT_W = ROL_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic [AMT_W-1:0] cmd_amt_i,
    input  logic [CNT_W-1:0] cmd_steps_i,
    output logic [WIDTH-1:0] sh_a_o,
    output logic [AMT_W-1:0] sh_amt_o,
    input  logic [WIDTH-1:0] sh_y_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    output logic             busy_o
);

    rol_seq_state_e   state_q, state_d;
    logic [WIDTH-1:0] operand_q;
    logic [AMT_W-1:0] amount_q;
    logic [CNT_W-1:0] remaining_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid_i) state_d = ROTATE;
            ROTATE:  state_d = HOLD;
            HOLD:    if (out_ready_i) state_d = out_last_q ? IDLE : ROTATE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE);
        out_valid_o = (state_q == HOLD);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            operand_q   <= '0;
            amount_q    <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        operand_q   <= cmd_data_i;
                        amount_q    <= cmd_amt_i;
                        remaining_q <= cmd_steps_i;
                    end
                end
                ROTATE: begin
                    out_data_q <= sh_y_i;
                    out_last_q <= (remaining_q == '0);
                end
                HOLD: begin
                    // The accepted result becomes the next operand; amount
                    // stays fixed for the whole command.
                    if (out_ready_i && !out_last_q) begin
                        operand_q <= out_data_q;
                        if (remaining_q != '0) begin
                            remaining_q <= remaining_q - CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sh_a_o     = operand_q;
    assign sh_amt_o   = amount_q;
    assign out_data_o = out_data_q;
    assign out_last_o = out_last_q;

endmodule

// File: tb/tb_rol_rotate_sequencer.sv
module tb_rol_rotate_sequencer;
    import rol_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [3:0] cmd_data_i;
    logic [1:0] cmd_amt_i;
    logic [3:0] cmd_steps_i;
    logic [3:0] sh_a_o;
    logic [1:0] sh_amt_o;
    logic [3:0] sh_y_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [3:0] out_data_o;
    logic       out_last_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    rol_rotate_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_data_i(cmd_data_i), .cmd_amt_i(cmd_amt_i), .cmd_steps_i(cmd_steps_i),
        .sh_a_o(sh_a_o), .sh_amt_o(sh_amt_o), .sh_y_i(sh_y_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o)
    );

    rol_barrel_shifter shifter (
        .a_i(sh_a_o), .amt_i(sh_amt_o), .y_o(sh_y_i)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents a command and returns 1 ns after the accepting edge.
    task automatic accept_cmd(input logic [3:0] d, input logic [1:0] a, input logic [3:0] s);
        cmd_data_i  = d;
        cmd_amt_i   = a;
        cmd_steps_i = s;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        cmd_valid_i = 1'b0; cmd_data_i = '0; cmd_amt_i = '0; cmd_steps_i = '0;
        out_ready_i = 1'b1;
        #12;
        checks++;
        if ({cmd_ready_o, busy_o, out_valid_o, out_last_o, out_data_o, sh_a_o, sh_amt_o}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00}) begin
            errors++;
            $display("FAIL reset_values: ready=%b busy=%b valid=%b last=%b data=%b a=%b amt=%b",
                     cmd_ready_o, busy_o, out_valid_o, out_last_o, out_data_o, sh_a_o, sh_amt_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_multi_step();
        logic [3:0] exp_d [4] = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};
        out_ready_i = 1'b1;
        accept_cmd(4'b1011, 2'b01, 4'd3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid_o !== 1'b0 || busy_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL multi_rotate_cycle beat %0d: valid=%b busy=%b ready=%b want 0 1 0",
                         i, out_valid_o, busy_o, cmd_ready_o);
            end
            tick();
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== exp_d[i] || out_last_o !== (i == 3)) begin
                errors++;
                $display("FAIL multi_beat %0d: valid=%b data=%b last=%b want 1 %b %b",
                         i, out_valid_o, out_data_o, out_last_o, exp_d[i], (i == 3));
            end
            tick();
        end
        checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL multi_idle_after: ready=%b busy=%b valid=%b want 1 0 0",
                     cmd_ready_o, busy_o, out_valid_o);
        end
    endtask

    task automatic test_single_beat();
        out_ready_i = 1'b1;
        accept_cmd(4'b1011, 2'b10, 4'd0);
        checks++;
        if (out_valid_o !== 1'b0 || sh_a_o !== 4'b1011 || sh_amt_o !== 2'b10) begin
            errors++;
            $display("FAIL single_rotate_cycle: valid=%b a=%b amt=%b want 0 1011 10",
                     out_valid_o, sh_a_o, sh_amt_o);
        end
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 4'b1110 || out_last_o !== 1'b1) begin
            errors++;
            $display("FAIL single_beat: valid=%b data=%b last=%b want 1 1110 1",
                     out_valid_o, out_data_o, out_last_o);
        end
        tick();
        checks++;
        if (cmd_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_after: ready=%b valid=%b want 1 0", cmd_ready_o, out_valid_o);
        end
    endtask

    task automatic test_zero_amount();
        out_ready_i = 1'b1;
        accept_cmd(4'b0110, 2'b00, 4'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== 4'b0110 || out_last_o !== (i == 2)) begin
                errors++;
                $display("FAIL zero_amt_beat %0d: valid=%b data=%b last=%b want 1 0110 %b",
                         i, out_valid_o, out_data_o, out_last_o, (i == 2));
            end
            tick();
        end
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_amt_idle: ready=%b want 1", cmd_ready_o);
        end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        accept_cmd(4'b1000, 2'b11, 4'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== 4'b0100 || out_last_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b data=%b last=%b want 1 0100 0",
                         i, out_valid_o, out_data_o, out_last_o);
            end
            if (i < 4) tick();
        end
        out_ready_i = 1'b1;
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || sh_a_o !== 4'b0100) begin
            errors++;
            $display("FAIL bp_feedback: valid=%b a=%b want 0 0100", out_valid_o, sh_a_o);
        end
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 4'b0010 || out_last_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_last_beat: valid=%b data=%b last=%b want 1 0010 1",
                     out_valid_o, out_data_o, out_last_o);
        end
        tick();
    endtask

    task automatic test_cmd_while_busy();
        out_ready_i = 1'b0;
        accept_cmd(4'b1011, 2'b01, 4'd1);
        tick();
        cmd_data_i = 4'b0001; cmd_amt_i = 2'b01; cmd_steps_i = 4'd0;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cmd_ready_o !== 1'b0 || out_data_o !== 4'b0111 || sh_a_o !== 4'b1011 || sh_amt_o !== 2'b01) begin
                errors++;
                $display("FAIL busy_ignore cycle %0d: ready=%b data=%b a=%b amt=%b want 0 0111 1011 01",
                         i, cmd_ready_o, out_data_o, sh_a_o, sh_amt_o);
            end
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        checks++;
        if (sh_a_o !== 4'b0111 || cmd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_feedback: a=%b ready=%b want 0111 0", sh_a_o, cmd_ready_o);
        end
        tick();
        checks++;
        if (out_data_o !== 4'b1110 || out_last_o !== 1'b1 || out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_first_last: data=%b last=%b valid=%b want 1110 1 1",
                     out_data_o, out_last_o, out_valid_o);
        end
        tick();
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_back_idle: ready=%b want 1", cmd_ready_o);
        end
        tick();
        cmd_valid_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || sh_a_o !== 4'b0001 || sh_amt_o !== 2'b01) begin
            errors++;
            $display("FAIL busy_second_accept: busy=%b a=%b amt=%b want 1 0001 01",
                     busy_o, sh_a_o, sh_amt_o);
        end
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 4'b0010 || out_last_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_second_beat: valid=%b data=%b last=%b want 1 0010 1",
                     out_valid_o, out_data_o, out_last_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_command();
        int stray;
        out_ready_i = 1'b1;
        accept_cmd(4'b1011, 2'b01, 4'd3);
        tick();
        tick();
        out_ready_i = 1'b0;
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 4'b1110) begin
            errors++;
            $display("FAIL rst_pre_hold: valid=%b data=%b want 1 1110", out_valid_o, out_data_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({cmd_ready_o, busy_o, out_valid_o, out_last_o, out_data_o, sh_a_o, sh_amt_o}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00}) begin
            errors++;
            $display("FAIL rst_async_clear: ready=%b busy=%b valid=%b last=%b data=%b a=%b amt=%b",
                     cmd_ready_o, busy_o, out_valid_o, out_last_o, out_data_o, sh_a_o, sh_amt_o);
        end
        tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        out_ready_i = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid_o !== 1'b0 || busy_o !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rst_no_more_beats: stray cycles=%0d want 0", stray);
        end
        accept_cmd(4'b0110, 2'b01, 4'd0);
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 4'b1100 || out_last_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_next_cmd: valid=%b data=%b last=%b want 1 1100 1",
                     out_valid_o, out_data_o, out_last_o);
        end
        tick();
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_next_idle: ready=%b want 1", cmd_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_multi_step();
        test_single_beat();
        test_zero_amount();
        test_backpressure();
        test_cmd_while_busy();
        test_reset_mid_command();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
